// File: rtl/cpu_memory_arbiter_if.sv
// Bus bundle between the two requesters (instruction cache refill port and
// CPU data port), the arbiter and the pipelined 16-bit memory port.
//   slave  : arbiter view (takes requests and memory responses, drives
//            acceptance, returns and memory requests)
//   master : environment view (requesters plus memory)
interface cpu_memory_arbiter_if;
    // instruction cache refill port
    logic [14:0] instr_address;
    logic        instr_rd_req;
    logic        instr_will_queue;
    logic        instr_success;
    logic [14:0] instr_requested_address;
    logic [15:0] instr_data;
    // CPU data port
    logic [14:0] data_address;
    logic        data_rd_req;
    logic        data_wr_req;
    logic [15:0] data_wr_data;
    logic [1:0]  data_wr_mask;
    logic        data_ready;
    logic        data_rd_valid;
    logic [15:0] data_rd_data;
    // memory port
    logic [14:0] mem_address;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_wr_data;
    logic [1:0]  mem_wr_mask;
    logic        mem_grant;
    logic [15:0] mem_rd_data;

    modport slave (
        input  instr_address, instr_rd_req,
        input  data_address, data_rd_req, data_wr_req, data_wr_data, data_wr_mask,
        input  mem_grant, mem_rd_data,
        output instr_will_queue, instr_success, instr_requested_address, instr_data,
        output data_ready, data_rd_valid, data_rd_data,
        output mem_address, mem_rd, mem_wr, mem_wr_data, mem_wr_mask
    );

    modport master (
        output instr_address, instr_rd_req,
        output data_address, data_rd_req, data_wr_req, data_wr_data, data_wr_mask,
        output mem_grant, mem_rd_data,
        input  instr_will_queue, instr_success, instr_requested_address, instr_data,
        input  data_ready, data_rd_valid, data_rd_data,
        input  mem_address, mem_rd, mem_wr, mem_wr_data, mem_wr_mask
    );
endinterface

// File: rtl/cpu_memory_arbiter.sv
// Arbitrates one pipelined 16-bit memory port between the instruction cache
// refill port (read-only) and the CPU data port (read/write). The data port
// has priority; the instruction port is forced a slot after losing
// STARVE_LIMIT consecutive cycles. In-flight reads carry a tag
// {valid, owner, address} down a fixed READ_LATENCY-deep pipeline so each
// returned word is routed to its owner with the address it came from.
// Ports:
//   CLK  - system clock
//   RST  - asynchronous reset, active-high
//   bus  - cpu_memory_arbiter_if.slave (requester, return and memory signals)
module cpu_memory_arbiter #(
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    cpu_memory_arbiter_if.slave   bus
);
    localparam int unsigned LAST       = READ_LATENCY - 1;
    localparam logic [2:0]  STARVE_MAX = 3'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_INSTR,
        GNT_DATA
    } grant_t;

    grant_t      grant;
    logic        data_req;
    logic        accept_rd;
    logic [2:0]  starve_cnt;

    logic        tag_valid [READ_LATENCY];
    logic        tag_instr [READ_LATENCY];
    logic [14:0] tag_addr  [READ_LATENCY];

    assign data_req = bus.data_rd_req | bus.data_wr_req;

    // Grant decision and memory request mux; reset forces the idle grant.
    always_comb begin
        grant                = GNT_NONE;
        bus.mem_address      = '0;
        bus.mem_rd           = 1'b0;
        bus.mem_wr           = 1'b0;
        bus.mem_wr_data      = '0;
        bus.mem_wr_mask      = '0;
        bus.instr_will_queue = 1'b0;
        bus.data_ready       = 1'b0;
        accept_rd            = 1'b0;

        if (!RST) begin
            if (bus.instr_rd_req && (starve_cnt == STARVE_MAX || !data_req))
                grant = GNT_INSTR;
            else if (data_req)
                grant = GNT_DATA;
        end

        case (grant)
            GNT_INSTR: begin
                bus.mem_address      = bus.instr_address;
                bus.mem_rd           = 1'b1;
                bus.instr_will_queue = bus.mem_grant;
                accept_rd            = bus.mem_grant;
            end
            GNT_DATA: begin
                bus.mem_address = bus.data_address;
                bus.data_ready  = bus.mem_grant;
                // read+write together is a write
                if (bus.data_wr_req) begin
                    bus.mem_wr      = 1'b1;
                    bus.mem_wr_data = bus.data_wr_data;
                    bus.mem_wr_mask = bus.data_wr_mask;
                end else begin
                    bus.mem_rd = 1'b1;
                    accept_rd  = bus.mem_grant;
                end
            end
            default: ;
        endcase
    end

    // Saturating count of consecutive cycles the instruction port waited.
    // Holding at the limit keeps the forced slot through grant stalls.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            starve_cnt <= '0;
        else if (!bus.instr_rd_req || bus.instr_will_queue)
            starve_cnt <= '0;
        else if (starve_cnt < STARVE_MAX)
            starve_cnt <= starve_cnt + 3'd1;
    end

    // Fixed-latency tag pipeline; never stalls.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                tag_valid[i] <= 1'b0;
                tag_instr[i] <= 1'b0;
                tag_addr[i]  <= '0;
            end
        end else begin
            tag_valid[0] <= accept_rd;
            tag_instr[0] <= (grant == GNT_INSTR);
            tag_addr[0]  <= bus.mem_address;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_instr[i] <= tag_instr[i-1];
                tag_addr[i]  <= tag_addr[i-1];
            end
        end
    end

    assign bus.instr_success           = tag_valid[LAST] & tag_instr[LAST];
    assign bus.instr_requested_address = tag_addr[LAST];
    assign bus.instr_data              = bus.mem_rd_data;
    assign bus.data_rd_valid           = tag_valid[LAST] & ~tag_instr[LAST];
    assign bus.data_rd_data            = bus.mem_rd_data;
endmodule

// File: doc/cpu_memory_arbiter.md
Name: cpu_memory_arbiter

Overview:
- Arbitrates one pipelined 16-bit memory port between two requesters: the instruction cache refill port (read-only) and the CPU data port (read/write).
- Sits directly downstream of the instruction cache. Produces its `memory_success`, `memory_requested_address`, `memory_data` and `will_queue` inputs.
- Tracks in-flight reads with a tag pipeline so that each returned word is routed to its owner together with the word address it was fetched from.

Parameters:
- READ_LATENCY, 2, cycles from read acceptance to `mem_rd_data` valid; legal range 1–4.
- STARVE_LIMIT, 4, consecutive cycles the instruction port may lose to the data port before it is forced a slot.

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous reset, active-high
- instr_address  in  15  instruction cache refill word address
- instr_rd_req  in  1  instruction cache read request
- instr_will_queue  out  1  instruction request accepted this cycle
- instr_success  out  1  returned word valid for the instruction cache
- instr_requested_address  out  15  address of the returned instruction word
- instr_data  out  16  returned instruction word
- data_address  in  15  data port word address
- data_rd_req  in  1  data read request
- data_wr_req  in  1  data write request
- data_wr_data  in  16  write data
- data_wr_mask  in  2  byte enables; bit1 = high byte
- data_ready  out  1  data request accepted this cycle
- data_rd_valid  out  1  returned data read word valid
- data_rd_data  out  16  returned data read word
- mem_address  out  15  memory word address
- mem_rd  out  1  memory read strobe
- mem_wr  out  1  memory write strobe
- mem_wr_data  out  16  memory write data
- mem_wr_mask  out  2  memory byte enables
- mem_grant  in  1  memory accepts the presented request this cycle
- mem_rd_data  in  16  read data, valid READ_LATENCY cycles after an accepted read

Behaviour:
- **Grant decision.** Combinational, evaluated every cycle.
  - `data_req = data_rd_req | data_wr_req`.
  - Default priority: the data port wins over the instruction port.
  - Forced slot: if `starve_cnt == STARVE_LIMIT` and `instr_rd_req` is high, the instruction port wins.
  - Memory outputs are driven from the winner. `mem_rd`/`mem_wr` are 0 when there is no request.
  - A simultaneous `data_rd_req` and `data_wr_req` is treated as a write.
  - For instruction and read cycles, `mem_wr_mask = 2'b00`.
- **Acceptance.** A request is accepted when it wins and `mem_grant` is 1.
  - `instr_will_queue = instr wins & mem_grant`.
  - `data_ready = data wins & mem_grant`.
  - Both are combinational, and at most one is high in any cycle.
  - A requester that is not accepted holds its request; its inputs are stable until accepted.
- **Starvation counter.** 3-bit register `starve_cnt`.
  - Increments when `instr_rd_req` is high and not accepted, saturating at STARVE_LIMIT.
  - Clears on `instr_will_queue` or when `instr_rd_req` is 0.
  - If `mem_grant = 0` while the instruction port holds the forced slot, the slot persists until it is accepted.
- **Tag pipeline.** READ_LATENCY stages, each holding {valid, owner(instr/data), address[14:0]}.
  - Stage 0 loads {1, owner, `mem_address`} on an accepted read. Otherwise stage 0 loads valid = 0.
  - Accepted writes enter no tag.
  - Stages shift every cycle and never stall; memory latency is fixed.
- **Return path.** Combinational from the last tag stage.
  - `instr_success = last.valid & (last.owner == instr)`.
  - `instr_requested_address = last.address`, `instr_data = mem_rd_data`.
  - `data_rd_valid` follows the same rule for data-owned tags, with `data_rd_data = mem_rd_data`.
  - An accepted read in cycle T produces its success pulse in cycle T+READ_LATENCY, for exactly one cycle.
- **Throughput.** One accepted request per cycle; back-to-back reads return back-to-back.
- **Reset.**
  - While RST is high: all tag valids = 0, `starve_cnt = 0`, and the grant logic is forced idle.
  - Consequently, during reset: `mem_rd = mem_wr = 0`, `instr_will_queue = data_ready = 0`, `instr_success = data_rd_valid = 0`. Data and address outputs are don't-care, but driven 0 where cheap.
  - Reset mid-flight discards all outstanding reads: no success pulse is ever emitted for a read accepted before reset.
- **Ownership integrity.** Interleaved instruction and data reads return to their own owners, in issue order.

Test Plan:
1. **Instruction-only stream.** Keep `instr_rd_req` high with addresses 0x0100, 0x0101, 0x0102 and `mem_grant = 1`. Required: `instr_will_queue` high each cycle, and `instr_success` pulses at T+2, T+3, T+4 with matching addresses and data.
2. **Priority and starvation.** Keep `data_rd_req` and `instr_rd_req` both high continuously. Required: `data_ready` for 4 cycles, then `instr_will_queue` in cycle 5, then the data port resumes; this pattern repeats.
3. **Write path.** Issue `data_wr_req` with address 0x1234, data 0xBEEF, mask 2'b10. Required: `mem_wr = 1` with `mem_wr_mask = 2'b10`, `data_ready = 1`, and no `data_rd_valid` in the following 4 cycles.
4. **Grant stall.** Hold `mem_grant = 0` for 3 cycles while `instr_rd_req` is high. Required: `instr_will_queue = 0` during the stall, no tags issued, and `mem_address` held at the request address; the read is accepted on the first cycle `mem_grant = 1`.
5. **Interleaved owners.** Accept an instr read (0x0010), a data read (0x2000), then an instr read (0x0011) on consecutive cycles. Required: returns in order instr / data / instr, each on the correct port with its correct address.
6. **Reset mid-flight.** Assert RST one cycle after accepting 2 reads, then release. Required: no `instr_success` or `data_rd_valid` pulses for those reads, and all outputs 0 during RST.
